// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C definitions for target and master blocks
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } tgt_state_e;

  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;
  localparam logic [6:0] GENERAL_CALL = 7'h00;

endpackage

// File: rtl/i2c_slave_regs_if.sv
// rtl/i2c_slave_regs_if.sv - host-side register port of the I2C register target
interface i2c_slave_regs_if #(
  parameter int PTR_W = 4
);
  logic             host_we;
  logic [PTR_W-1:0] host_addr;
  logic [7:0]       host_wdata;
  logic [7:0]       host_rdata;
  logic             bus_wr_valid;
  logic [PTR_W-1:0] bus_wr_addr;
  logic [7:0]       bus_wr_data;

  modport master (
    output host_we, host_addr, host_wdata,
    input  host_rdata, bus_wr_valid, bus_wr_addr, bus_wr_data
  );

  modport slave (
    input  host_we, host_addr, host_wdata,
    output host_rdata, bus_wr_valid, bus_wr_addr, bus_wr_data
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchroniser with edge and START/STOP detection
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;

  // synchroniser chains plus one edge-detect stage; reset to the idle-high bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_o;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SDA edges only count as conditions while SCL stayed high across both samples
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_o;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_o;
endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target with pointer-addressed byte register file
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  inout  wire               sda,
  input  logic [6:0]        my_address,
  output logic              busy,
  i2c_slave_regs_if.slave   host
);
  localparam int PTR_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REGS - 1);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl),
    .sda_i      (sda),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  tgt_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [6:0]       rx_q, rx_d;
  logic [6:0]       tx_q, tx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             ph_q, ph_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             bus_wr_valid_q;
  logic [PTR_W-1:0] bus_wr_addr_q;
  logic [7:0]       bus_wr_data_q;
  logic [7:0]       regs_q [NUM_REGS];

  logic [7:0]       rx_byte;
  logic [7:0]       cur_byte;
  logic [PTR_W-1:0] ptr_inc;
  logic             bus_we;
  logic             host_ok;
  logic             host_in_range;

  assign rx_byte       = {rx_q, sda_s};
  assign cur_byte      = regs_q[ptr_q];
  assign ptr_inc       = (ptr_q == LAST_IDX) ? '0 : ptr_q + PTR_W'(1);
  assign host_in_range = 32'(host.host_addr) < NUM_REGS;
  // bus wins a same-register collision; a different register lets both land
  assign host_ok       = host.host_we && host_in_range && !(bus_we && host.host_addr == ptr_q);

  // state and bit-level bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      rx_q           <= '0;
      tx_q           <= '0;
      ptr_q          <= '0;
      rw_q           <= 1'b0;
      ph_q           <= 1'b0;
      oe_q           <= 1'b0;
      busy_q         <= 1'b0;
      bus_wr_valid_q <= 1'b0;
      bus_wr_addr_q  <= '0;
      bus_wr_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rx_q           <= rx_d;
      tx_q           <= tx_d;
      ptr_q          <= ptr_d;
      rw_q           <= rw_d;
      ph_q           <= ph_d;
      oe_q           <= oe_d;
      busy_q         <= busy_d;
      bus_wr_valid_q <= bus_we;
      if (bus_we) begin
        bus_wr_addr_q <= ptr_q;
        bus_wr_data_q <= rx_byte;
      end
    end
  end

  // register file: host and bus write ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      if (host_ok) regs_q[host.host_addr] <= host.host_wdata;
      if (bus_we)  regs_q[ptr_q] <= rx_byte;
    end
  end

  // next-state logic; ph_q marks that the ACK slot has already been driven
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    ph_d    = ph_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    bus_we  = 1'b0;
    if (stop_det) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      ph_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      ph_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_WAIT_STOP: ;
        ST_ADDR: if (scl_rise) begin
          rx_d  = rx_byte[6:0];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (rx_byte[7:1] == my_address && rx_byte[7:1] != GENERAL_CALL) begin
              rw_d    = rx_byte[0];
              busy_d  = 1'b1;
              ph_d    = 1'b0;
              state_d = ST_ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (!ph_q) begin
            oe_d = ~ACK;
            ph_d = 1'b1;
          end else begin
            ph_d  = 1'b0;
            cnt_d = '0;
            if (rw_q) begin
              tx_d    = cur_byte[6:0];
              oe_d    = ~cur_byte[7];
              state_d = ST_RDATA;
            end else begin
              oe_d    = 1'b0;
              state_d = ST_PTR;
            end
          end
        end
        ST_PTR: if (scl_rise) begin
          rx_d  = rx_byte[6:0];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (32'(rx_byte) < NUM_REGS) begin
              ptr_d   = rx_byte[PTR_W-1:0];
              ph_d    = 1'b0;
              state_d = ST_PTR_ACK;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
          if (!ph_q) begin
            oe_d = ~ACK;
            ph_d = 1'b1;
          end else begin
            oe_d    = 1'b0;
            ph_d    = 1'b0;
            cnt_d   = '0;
            state_d = ST_WDATA;
          end
        end
        ST_WDATA: if (scl_rise) begin
          rx_d  = rx_byte[6:0];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            bus_we  = 1'b1;
            ptr_d   = ptr_inc;
            ph_d    = 1'b0;
            state_d = ST_WDATA_ACK;
          end
        end
        ST_RDATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = ST_RDATA_ACK;
            end else begin
              oe_d = ~tx_q[6];
              tx_d = {tx_q[5:0], 1'b0};
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr_inc;
            if (sda_s == NACK) state_d = ST_WAIT_STOP;
          end else if (scl_fall) begin
            tx_d    = cur_byte[6:0];
            oe_d    = ~cur_byte[7];
            cnt_d   = '0;
            state_d = ST_RDATA;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // host read port: combinational view of the register file
  always_comb begin
    host.host_rdata = 8'h00;
    if (host_in_range) host.host_rdata = regs_q[host.host_addr];
  end

  assign host.bus_wr_valid = bus_wr_valid_q;
  assign host.bus_wr_addr  = bus_wr_addr_q;
  assign host.bus_wr_data  = bus_wr_data_q;
  assign busy              = busy_q;
  assign sda               = oe_q ? 1'b0 : 1'bz;
endmodule
